// File: rtl/count_seq_monitor.sv
// Sequence monitor for a MIN_VAL..MAX_VAL modulo counter: acquires lock after a
// run of correct steps, flags wrong/illegal samples, and keeps saturating statistics.
module count_seq_monitor #(
  parameter int W        = 3,
  parameter int MIN_VAL  = 2,
  parameter int MAX_VAL  = 6,
  parameter int LOCK_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     q_in,
  input  logic             q_valid,
  input  logic             cnt_clr,
  output logic             locked,
  output logic [W-1:0]     expected,
  output logic             seq_err,
  output logic             illegal_err,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [W-1:0] MIN_V = W'(MIN_VAL);
  localparam logic [W-1:0] MAX_V = W'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  function automatic logic [W-1:0] succ(input logic [W-1:0] v);
    if (v == MAX_V) begin
      return MIN_V;
    end else begin
      return v + W'(1);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  state_t           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic [W-1:0]     expected_q, expected_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal_err_q, illegal_err_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             legal_s, step_ok_s, wrap_inc_s, err_inc_s;

  // Next-state, pulse and statistics logic for one sample.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    run_d         = run_q;
    seq_err_d     = 1'b0;
    illegal_err_d = 1'b0;
    wrap_inc_s    = 1'b0;
    err_inc_s     = 1'b0;
    legal_s       = (q_in >= MIN_V) && (q_in <= MAX_V);
    step_ok_s     = (q_in == succ(prev_q));

    if (q_valid) begin
      if (!legal_s) begin
        // Errors only count against a locked stream.
        illegal_err_d = 1'b1;
        err_inc_s     = (state_q == LOCK);
        state_d       = IDLE;
        prev_d        = '0;
        run_d         = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = ACQ;
            prev_d  = q_in;
            run_d   = '0;
          end
          ACQ: begin
            prev_d = q_in;
            if (!step_ok_s) begin
              run_d = '0;
            end else if (run_q == RUN_W'(LOCK_LEN - 1)) begin
              state_d = LOCK;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
          LOCK: begin
            prev_d = q_in;
            if (step_ok_s) begin
              wrap_inc_s = (prev_q == MAX_V) && (q_in == MIN_V);
            end else begin
              seq_err_d = 1'b1;
              err_inc_s = 1'b1;
              run_d     = '0;
              state_d   = ACQ;
            end
          end
          default: begin
            state_d = IDLE;
            prev_d  = '0;
            run_d   = '0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (cnt_clr) begin
      wrap_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      wrap_cnt_d = wrap_inc_s ? sat_inc(wrap_cnt_q) : wrap_cnt_q;
      err_cnt_d  = err_inc_s  ? sat_inc(err_cnt_q)  : err_cnt_q;
    end

    locked_d   = (state_d == LOCK);
    expected_d = (state_d == IDLE) ? W'(0) : succ(prev_d);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      run_q         <= '0;
      locked_q      <= 1'b0;
      expected_q    <= '0;
      seq_err_q     <= 1'b0;
      illegal_err_q <= 1'b0;
      wrap_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      locked_q      <= locked_d;
      expected_q    <= expected_d;
      seq_err_q     <= seq_err_d;
      illegal_err_q <= illegal_err_d;
      wrap_cnt_q    <= wrap_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign expected    = expected_q;
  assign seq_err     = seq_err_q;
  assign illegal_err = illegal_err_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: a default-width and a 2-bit-counter instance
// share stimulus and are compared each cycle against a behavioural model.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] q_in = 3'd0;
  logic       q_valid = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       locked_a, seq_err_a, illegal_err_a;
  logic [2:0] expected_a;
  logic [7:0] wrap_cnt_a, err_cnt_a;
  logic       locked_b, seq_err_b, illegal_err_b;
  logic [2:0] expected_b;
  logic [1:0] wrap_cnt_b, err_cnt_b;

  int total = 0;
  int bad   = 0;

  // Model: mode 0=idle 1=acquiring 2=locked.
  int mode = 0, prev = 0, run = 0;
  int m_locked = 0, m_exp = 0, m_seq = 0, m_ill = 0;
  int m_wrap_a = 0, m_err_a = 0, m_wrap_b = 0, m_err_b = 0;

  always #5 clk = ~clk;

  count_seq_monitor dut_a (
    .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid), .cnt_clr(cnt_clr),
    .locked(locked_a), .expected(expected_a), .seq_err(seq_err_a),
    .illegal_err(illegal_err_a), .wrap_cnt(wrap_cnt_a), .err_cnt(err_cnt_a)
  );

  count_seq_monitor #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid), .cnt_clr(cnt_clr),
    .locked(locked_b), .expected(expected_b), .seq_err(seq_err_b),
    .illegal_err(illegal_err_b), .wrap_cnt(wrap_cnt_b), .err_cnt(err_cnt_b)
  );

  function automatic int nxt(input int v);
    return (v == 6) ? 2 : v + 1;
  endfunction

  function automatic int bump(input int c, input int cap);
    return (c >= cap) ? cap : c + 1;
  endfunction

  task automatic model_step(input int v, input bit valid, input bit clr, input bit r);
    bit w_inc, e_inc;
    w_inc = 1'b0;
    e_inc = 1'b0;
    m_seq = 0;
    m_ill = 0;
    if (r) begin
      mode = 0; prev = 0; run = 0;
      m_wrap_a = 0; m_err_a = 0; m_wrap_b = 0; m_err_b = 0;
    end else begin
      if (valid) begin
        if (v < 2 || v > 6) begin
          m_ill = 1;
          e_inc = (mode == 2);
          mode = 0; prev = 0; run = 0;
        end else if (mode == 0) begin
          mode = 1; prev = v; run = 0;
        end else if (v == nxt(prev)) begin
          w_inc = (mode == 2) && (prev == 6);
          prev = v;
          if (mode == 1) begin
            run = run + 1;
            if (run == 3) begin
              mode = 2;
              run = 0;
            end
          end
        end else begin
          if (mode == 2) begin
            m_seq = 1;
            e_inc = 1'b1;
          end
          mode = 1; prev = v; run = 0;
        end
      end
      if (clr) begin
        m_wrap_a = 0; m_err_a = 0; m_wrap_b = 0; m_err_b = 0;
      end else begin
        if (w_inc) begin
          m_wrap_a = bump(m_wrap_a, 255);
          m_wrap_b = bump(m_wrap_b, 3);
        end
        if (e_inc) begin
          m_err_a = bump(m_err_a, 255);
          m_err_b = bump(m_err_b, 3);
        end
      end
    end
    m_locked = (mode == 2) ? 1 : 0;
    m_exp    = (mode == 0) ? 0 : nxt(prev);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("locked_a", 32'(locked_a), 32'(m_locked));
    chk("expected_a", 32'(expected_a), 32'(m_exp));
    chk("seq_err_a", 32'(seq_err_a), 32'(m_seq));
    chk("illegal_err_a", 32'(illegal_err_a), 32'(m_ill));
    chk("wrap_cnt_a", 32'(wrap_cnt_a), 32'(m_wrap_a));
    chk("err_cnt_a", 32'(err_cnt_a), 32'(m_err_a));
    chk("locked_b", 32'(locked_b), 32'(m_locked));
    chk("expected_b", 32'(expected_b), 32'(m_exp));
    chk("seq_err_b", 32'(seq_err_b), 32'(m_seq));
    chk("illegal_err_b", 32'(illegal_err_b), 32'(m_ill));
    chk("wrap_cnt_b", 32'(wrap_cnt_b), 32'(m_wrap_b));
    chk("err_cnt_b", 32'(err_cnt_b), 32'(m_err_b));
  endtask

  // One clock: drive at negedge, check #1 after the sampling posedge.
  task automatic cyc(input int v, input bit valid, input bit clr = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    q_in    = 3'(v);
    q_valid = valid;
    cnt_clr = clr;
    rst     = r;
    model_step(v, valid, clr, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic feed(input int v);
    cyc(v, 1'b1);
  endtask

  task automatic relock();
    feed(2); feed(3); feed(4); feed(5);
  endtask

  initial begin
    // Reset
    cyc(0, 1'b0, 1'b0, 1'b1);
    chk("pin_rst_locked", 32'(locked_a), 32'd0);
    chk("pin_rst_expected", 32'(expected_a), 32'd0);

    // Lock on 2,3,4,5
    feed(2); feed(3); feed(4);
    chk("pin_not_yet_locked", 32'(locked_a), 32'd0);
    feed(5);
    chk("pin_locked", 32'(locked_a), 32'd1);
    chk("pin_lock_expected", 32'(expected_a), 32'd6);
    chk("pin_lock_err", 32'(err_cnt_a), 32'd0);

    // Two wraps while locked
    feed(6); feed(2); feed(3); feed(4); feed(5); feed(6); feed(2);
    chk("pin_wrap2", 32'(wrap_cnt_a), 32'd2);
    chk("pin_wrap_locked", 32'(locked_a), 32'd1);

    // Invalid cycles with q_in toggling
    cyc(7, 1'b0); cyc(0, 1'b0); cyc(5, 1'b0); cyc(2, 1'b0); cyc(7, 1'b0);
    chk("pin_hold_wrap", 32'(wrap_cnt_a), 32'd2);
    chk("pin_hold_expected", 32'(expected_a), 32'd3);

    // Skip from 3 to 5
    feed(3);
    feed(5);
    chk("pin_skip_seq", 32'(seq_err_a), 32'd1);
    chk("pin_skip_err", 32'(err_cnt_a), 32'd1);
    chk("pin_skip_locked", 32'(locked_a), 32'd0);
    chk("pin_skip_expected", 32'(expected_a), 32'd6);
    cyc(0, 1'b0);
    chk("pin_skip_pulse_end", 32'(seq_err_a), 32'd0);
    feed(6); feed(2); feed(3);
    chk("pin_relocked", 32'(locked_a), 32'd1);

    // Illegal values
    feed(7);
    chk("pin_ill_pulse", 32'(illegal_err_a), 32'd1);
    chk("pin_ill_err", 32'(err_cnt_a), 32'd2);
    chk("pin_ill_expected", 32'(expected_a), 32'd0);
    feed(0);
    chk("pin_idle_ill_pulse", 32'(illegal_err_a), 32'd1);
    chk("pin_idle_ill_err", 32'(err_cnt_a), 32'd2);

    // Repeated value while locked, then more locked errors to saturate the 2-bit counter
    relock();
    feed(5);
    chk("pin_repeat_seq", 32'(seq_err_a), 32'd1);
    for (int k = 0; k < 4; k++) begin
      relock();
      feed(7);
    end
    chk("pin_sat_err_b", 32'(err_cnt_b), 32'd3);
    chk("pin_err_a", 32'(err_cnt_a), 32'd7);

    // Clear colliding with a wrap
    relock();
    feed(6);
    cyc(2, 1'b1, 1'b1);
    chk("pin_clr_wrap", 32'(wrap_cnt_a), 32'd0);
    chk("pin_clr_err", 32'(err_cnt_a), 32'd0);
    chk("pin_clr_locked", 32'(locked_a), 32'd1);

    // Four wraps, then reset with a valid sample present
    for (int k = 0; k < 4; k++) begin
      feed(3); feed(4); feed(5); feed(6); feed(2);
    end
    chk("pin_wrap4", 32'(wrap_cnt_a), 32'd4);
    cyc(2, 1'b1, 1'b0, 1'b1);
    chk("pin_mid_rst_locked", 32'(locked_a), 32'd0);
    chk("pin_mid_rst_wrap", 32'(wrap_cnt_a), 32'd0);
    chk("pin_mid_rst_expected", 32'(expected_a), 32'd0);
    feed(4);
    chk("pin_after_rst_expected", 32'(expected_a), 32'd5);
    cyc(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit modulo counter that cycles 2->3->4->5->6->2.
- Samples the counter value on strobed cycles and checks it against the legal sequence.
- Declares lock after a run of correct steps, flags sequence and illegal-value errors, and keeps saturating wrap and error statistics for the test harness and status logic.

Parameters:
W, 3, width of the monitored count
MIN_VAL, 2, first value of the legal sequence (value after MAX_VAL)
MAX_VAL, 6, last value of the legal sequence
LOCK_LEN, 3, consecutive correct steps required to enter LOCK
CNT_W, 8, width of wrap_cnt and err_cnt

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
q_in  input  W  counter value; sampled only when q_valid=1
q_valid  input  1  one-cycle strobe per counter step
cnt_clr  input  1  synchronous clear of wrap_cnt/err_cnt only
locked  output  1  high while state==LOCK
expected  output  W  predicted next value; 0 in IDLE
seq_err  output  1  one-cycle pulse: legal but wrong value while locked
illegal_err  output  1  one-cycle pulse: value outside [MIN_VAL,MAX_VAL]
wrap_cnt  output  CNT_W  count of MAX_VAL->MIN_VAL transitions while locked, saturating
err_cnt  output  CNT_W  count of seq_err plus illegal_err while locked, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on posedge with rst=1, state=IDLE, prev=0, run=0, and all outputs are 0. Reset beats every other input, including a reset asserted mid-LOCK.
- succ(v) = MIN_VAL if v==MAX_VAL, else v+1. W-bit arithmetic.
- legal(v) = MIN_VAL<=v<=MAX_VAL.
- No state, counter, or pulse changes on cycles with q_valid=0. Pulses are 0 on those cycles.
- All outputs are registered. The response to a sample appears the cycle after the sampling edge (latency 1).
- A repeated identical value is a wrong step.
- IDLE:
  - Legal sample: prev=sample, run=0, go to ACQ.
  - Illegal sample: pulse illegal_err, stay in IDLE, err_cnt unchanged.
- ACQ:
  - sample==succ(prev): prev=sample, run+1. When run reaches LOCK_LEN, go to LOCK and clear run.
  - Legal but wrong: prev=sample, run=0, stay in ACQ. No seq_err.
  - Illegal: pulse illegal_err, go to IDLE, prev=0, err_cnt unchanged.
- LOCK:
  - Correct step: prev=sample. If prev was MAX_VAL and sample==MIN_VAL, increment wrap_cnt.
  - Legal but wrong: pulse seq_err, increment err_cnt, prev=sample, run=0, go to ACQ.
  - Illegal: pulse illegal_err, increment err_cnt, go to IDLE.
- expected = succ(prev) in ACQ and LOCK, 0 in IDLE. It updates together with state.
- wrap_cnt and err_cnt hold at all-ones; they never wrap to 0.
- cnt_clr=1 zeroes both counters in that cycle. It overrides a simultaneous increment (result is 0) and does not affect state, prev, run, or pulses.
- seq_err and illegal_err are never high in the same cycle.

Test Plan:
- Lock: rst, then valid samples 2,3,4,5 -> locked=1 the cycle after sample 5 (not earlier), expected=6, err_cnt=0.
- Wrap: from lock, feed 6,2,3,4,5,6,2 -> wrap_cnt=2, no error pulses, locked stays 1. Hold q_valid=0 for 5 cycles with q_in toggling -> no change.
- Skip: locked with prev=3, feed 5 -> seq_err pulse for one cycle, err_cnt=1, locked=0, expected=6. Then feed 6,2,3 -> locked=1 again.
- Illegal: locked, feed 7 -> illegal_err pulse, err_cnt increments, state IDLE, expected=0. In IDLE feed 0 -> illegal_err pulse, err_cnt unchanged.
- Saturation/clear: CNT_W=2 override, force 5 locked errors -> err_cnt=3 and holds. cnt_clr in the same cycle as a 6->2 wrap -> wrap_cnt=0.
- Reset mid-operation: locked with wrap_cnt=4, assert rst for 1 cycle together with q_valid=1 and q_in=2 -> all outputs 0, state IDLE, sample ignored.
